// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : oversampling UART receiver (start, LSB-first data, opt. parity, |
// |           stop). Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int EW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] VOTE_A    = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] VOTE_B    = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] DECIDE    = EW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [EW-1:0] DECIDE    = EW'(OVERSAMPLE / 2);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  bit_val;
  logic                  sample_pt;
  logic                  wrap;

`ifdef UART_RX_MAJORITY_EN
  // Two early samples are held; the third is the live line at the decision point.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (edge_cnt_q == VOTE_A) vote_d[0] = RX_IN;
    if (edge_cnt_q == VOTE_B) vote_d[1] = RX_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) vote_q <= 2'b00;
    else      vote_q <= vote_d;
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & RX_IN) | (vote_q[1] & RX_IN);
`else
  assign bit_val = RX_IN;
`endif

  assign sample_pt = (edge_cnt_q == DECIDE);
  assign wrap      = (edge_cnt_q == EDGE_LAST);

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = wrap ? '0 : edge_cnt_q + 1'b1;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_err_d      = par_err_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        // The detect edge counts as edge 0, so the counter leaves it at 1.
        if (!RX_IN) begin
          state_d    = START;
          edge_cnt_d = EW'(1);
          par_en_d   = parity_enable;
          par_type_d = parity_type;
          par_err_d  = 1'b0;
        end
      end
      START: begin
        if (sample_pt && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_pt) shift_d[bit_cnt_q] = bit_val;
        if (wrap) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_pt) par_err_d = (bit_val != (^shift_q ^ par_type_q));
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Leaving at mid-stop lets a start edge right after the stop bit be caught.
        if (sample_pt) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          if (!bit_val) begin
            stop_error_d = 1'b1;
          end else if (par_err_q) begin
            parity_error_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_err_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_err_q      <= par_err_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx : scoreboard bench for uart_rx; stimulus pushes expected       |
// |              pulses, a negedge monitor pops and compares them.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int DW = 8;
  localparam int OS = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_ADJ = 1;
`else
  localparam int LAT_ADJ = 0;
`endif
  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_STOP  = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          parity_enable;
  logic          parity_type;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          parity_error;
  logic          stop_error;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] last_good = '0;

  // flags = {stop_error, parity_error, Data_Valid}
  typedef struct {
    logic [2:0]    flags;
    logic [DW-1:0] pdata;
    int            at;
  } exp_t;
  exp_t sb[$];

  uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST && (Data_Valid || parity_error || stop_error)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got flags %b at cycle %0d required none",
                 {stop_error, parity_error, Data_Valid}, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_flags", 32'({stop_error, parity_error, Data_Valid}), 32'(e.flags));
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("pulse_pdata", 32'(P_DATA), 32'(e.pdata));
      end
    end
  end

  // Precondition for all drivers: called 1ns after a rising edge.
  task automatic drive_bit(input logic b, input logic glitch);
    RX_IN = b;
    if (glitch) begin
      // Invert only around the centre edge of the bit.
      repeat (OS / 2) @(posedge CLK);
      #1 RX_IN = ~b;
      @(posedge CLK);
      #1 RX_IN = b;
      repeat (OS / 2 - 1) @(posedge CLK);
    end else begin
      repeat (OS) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptype,
                            input logic pbit, input logic stopb, input int kind,
                            input int gap_bits, input int glitch_bit);
    exp_t e;
    int   f;
    parity_enable = pen;
    parity_type   = ptype;
    f = pen ? DW + 2 : DW + 1;
    e.at = cyc + f * OS + OS / 2 + 1 + LAT_ADJ;
    case (kind)
      K_VALID: e.flags = 3'b001;
      K_PAR:   e.flags = 3'b010;
      default: e.flags = 3'b100;
    endcase
    e.pdata = (kind == K_VALID) ? data : last_good;
    if (kind == K_VALID) last_good = data;
    sb.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(data[i], (i == glitch_bit));
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(stopb, 1'b0);
    for (int g = 0; g < gap_bits; g++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RST           = 1'b0;
    RX_IN         = 1'b1;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_dv",    32'(Data_Valid),   32'd0);
    check("reset_pe",    32'(parity_error), 32'd0);
    check("reset_se",    32'(stop_error),   32'd0);
    check("reset_pdata", 32'(P_DATA),       32'd0);
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // 1: plain frame, latency 77
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 2, -1);
    wait_drain();

    // 2: even parity, 0x3C has four ones -> correct parity bit is 0
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 2, -1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR,   2, -1);
    wait_drain();

    // 3: odd parity, 0x81 has two ones -> parity bit 1 is correct; stop driven 0
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, K_STOP, 3, -1);
    wait_drain();

    // 4: short low glitch is a false start
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (3 * OS) @(posedge CLK);
    #1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 2, -1);
    wait_drain();

    // 5: back-to-back frames, no idle gap
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 0, -1);
    send_frame(8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 2, -1);
    wait_drain();

    // 6: reset in the middle of frame 0xFF
    parity_enable = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    RST = 1'b0;
    #1;
    check("midreset_dv",    32'(Data_Valid),   32'd0);
    check("midreset_pe",    32'(parity_error), 32'd0);
    check("midreset_se",    32'(stop_error),   32'd0);
    check("midreset_pdata", 32'(P_DATA),       32'd0);
    last_good = '0;
    @(posedge CLK);
    #1 RX_IN = 1'b1;
    RST = 1'b1;
    repeat (2 * OS) @(posedge CLK);
    #1;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 2, -1);
    wait_drain();

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle glitch at the centre of data bit 2 must be outvoted.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 2, 2);
    wait_drain();
`endif

    check("final_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
